// File: rtl/mult_if_ds_rx_if.sv
// Sample/word handshake bundle for the data-selector capture block.
// The source side (master) drives samples and downstream ready; the capture block (slave) returns words.
interface mult_if_ds_rx_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_c;
  logic       in_late;
  logic       in_z;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_mask;
  logic       out_conflict;
  logic       out_partial;

  modport master (
    output in_valid, in_c, in_late, in_z, flush, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_conflict, out_partial
  );

  modport slave (
    input  in_valid, in_c, in_late, in_z, flush, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_conflict, out_partial
  );
endinterface

// File: rtl/mult_if_ds_rx.sv
// Rebuilds the 8-bit source word of the priority-mux selector from its serial samples
// and emits it, with a capture mask and conflict flag, through a single-entry output register.
module mult_if_ds_rx #(
  parameter logic [7:0] REQ_MASK = 8'h2F
) (
  input logic               clk,
  input logic               rst,
  mult_if_ds_rx_if.slave    bus
);

  // Only bits 0,1,2,3,5 can ever be routed, so other required bits are dropped.
  localparam logic [7:0] REQ = REQ_MASK & 8'h2F;

  logic [7:0] acc_data_q, acc_data_d;
  logic [7:0] acc_mask_q, acc_mask_d;
  logic       acc_conflict_q, acc_conflict_d;

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [7:0] out_mask_q, out_mask_d;
  logic       out_conflict_q, out_conflict_d;
  logic       out_partial_q, out_partial_d;

  logic [2:0] idx;
  logic [7:0] post_data;
  logic [7:0] post_mask;
  logic       post_conflict;
  logic       acc_complete;
  logic       post_complete;
  logic       out_free;
  logic       in_ready;
  logic       accept;
  logic       transfer;

  always_comb begin
    idx = 3'd5;
    if (bus.in_c[3] && !bus.in_late && !bus.in_c[0] && bus.in_c[1] && !bus.in_c[2])
      idx = 3'd3;
    else if (bus.in_c[0])
      idx = 3'd0;
    else if (!bus.in_c[1])
      idx = 3'd1;
    else if (bus.in_c[4])
      idx = 3'd2;
    else
      idx = 3'd5;
  end

  // A nonzero mask check keeps an empty accumulator from looking complete when REQ is zero.
  always_comb begin
    out_free     = !out_valid_q || bus.out_ready;
    acc_complete = ((acc_mask_q & REQ) == REQ) && (acc_mask_q != 8'h00);
    in_ready     = !(acc_complete && !out_free) && !(bus.flush && !out_free);
    accept       = bus.in_valid && in_ready;

    post_data     = acc_data_q;
    post_mask     = acc_mask_q;
    post_conflict = acc_conflict_q;
    if (accept) begin
      if (acc_mask_q[idx] && (acc_data_q[idx] != bus.in_z))
        post_conflict = 1'b1;
      post_data[idx] = bus.in_z;
      post_mask[idx] = 1'b1;
    end

    post_complete = ((post_mask & REQ) == REQ) && (post_mask != 8'h00);
    transfer      = out_free && (post_complete || (bus.flush && (post_mask != 8'h00)));
  end

  always_comb begin
    acc_data_d     = post_data;
    acc_mask_d     = post_mask;
    acc_conflict_d = post_conflict;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_mask_d     = out_mask_q;
    out_conflict_d = out_conflict_q;
    out_partial_d  = out_partial_q;

    if (out_valid_q && bus.out_ready)
      out_valid_d = 1'b0;

    if (transfer) begin
      out_valid_d    = 1'b1;
      out_data_d     = post_data;
      out_mask_d     = post_mask;
      out_conflict_d = post_conflict;
      out_partial_d  = !post_complete;
      acc_data_d     = 8'h00;
      acc_mask_d     = 8'h00;
      acc_conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_q     <= 8'h00;
      acc_mask_q     <= 8'h00;
      acc_conflict_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 8'h00;
      out_mask_q     <= 8'h00;
      out_conflict_q <= 1'b0;
      out_partial_q  <= 1'b0;
    end else begin
      acc_data_q     <= acc_data_d;
      acc_mask_q     <= acc_mask_d;
      acc_conflict_q <= acc_conflict_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_mask_q     <= out_mask_d;
      out_conflict_q <= out_conflict_d;
      out_partial_q  <= out_partial_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_mask     = out_mask_q;
  assign bus.out_conflict = out_conflict_q;
  assign bus.out_partial  = out_partial_q;

endmodule

// File: tb/tb_mult_if_ds_rx.sv
// Directed self-checking bench for mult_if_ds_rx with hand-computed expected words.
module tb_mult_if_ds_rx;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  mult_if_ds_rx_if bus ();

  mult_if_ds_rx #(.REQ_MASK(8'h2F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control codes routing bits 0,1,2,3,5 (late=0) in that order.
  logic [4:0] code_tab [5];
  initial code_tab = '{5'b00001, 5'b00000, 5'b10010, 5'b01010, 5'b00010};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, lets the edge happen, and returns #1 after it with valid/flush dropped.
  task automatic applyStimulus(input logic valid, input logic [4:0] c, input logic late,
                               input logic z, input logic fl);
    bus.in_valid = valid;
    bus.in_c     = c;
    bus.in_late  = late;
    bus.in_z     = z;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // Sends the five reachable bits with z taken from zbits in order 0,1,2,3,5.
  task automatic sendWord(input logic [4:0] zbits);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, code_tab[i], 1'b0, zbits[i], 1'b0);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_c     = 5'd0;
    bus.in_late  = 1'b0;
    bus.in_z     = 1'b0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid",    32'(bus.out_valid),    32'h0);
    checkOutput("rst_data",     32'(bus.out_data),     32'h0);
    checkOutput("rst_mask",     32'(bus.out_mask),     32'h0);
    checkOutput("rst_conflict", 32'(bus.out_conflict), 32'h0);
    checkOutput("rst_partial",  32'(bus.out_partial),  32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready),     32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Reachable bits: z = 1,0,1,1,1 on bits 0,1,2,3,5 gives 8'h2D.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, code_tab[i], 1'b0, (i == 1) ? 1'b0 : 1'b1, 1'b0);
    checkOutput("reach_not_yet", 32'(bus.out_valid), 32'h0);
    applyStimulus(1'b1, code_tab[4], 1'b0, 1'b1, 1'b0);
    checkOutput("reach_valid",    32'(bus.out_valid),    32'h1);
    checkOutput("reach_data",     32'(bus.out_data),     32'h2D);
    checkOutput("reach_mask",     32'(bus.out_mask),     32'h2F);
    checkOutput("reach_conflict", 32'(bus.out_conflict), 32'h0);
    checkOutput("reach_partial",  32'(bus.out_partial),  32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reach_drained", 32'(bus.out_valid), 32'h0);

    // Late gating: 01010 with late=1 lands in bit 5; flushed in the same cycle.
    applyStimulus(1'b1, 5'b01010, 1'b1, 1'b1, 1'b1);
    checkOutput("late_valid",   32'(bus.out_valid),   32'h1);
    checkOutput("late_data",    32'(bus.out_data),    32'h20);
    checkOutput("late_mask",    32'(bus.out_mask),    32'h20);
    checkOutput("late_partial", 32'(bus.out_partial), 32'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Conflict: bit 0 written 1 then 0; rest z = 1,1,0,0 -> data 8'h06.
    applyStimulus(1'b1, 5'b00001, 1'b0, 1'b1, 1'b0);
    sendWord(5'b00110);
    checkOutput("conf_valid",    32'(bus.out_valid),    32'h1);
    checkOutput("conf_data",     32'(bus.out_data),     32'h06);
    checkOutput("conf_mask",     32'(bus.out_mask),     32'h2F);
    checkOutput("conf_conflict", 32'(bus.out_conflict), 32'h1);
    checkOutput("conf_partial",  32'(bus.out_partial),  32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Backpressure: word A all ones held while word B (all zeros) fills.
    bus.out_ready = 1'b0;
    sendWord(5'b11111);
    checkOutput("bp_a_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("bp_a_data",  32'(bus.out_data),  32'h2F);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, code_tab[i], 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_mid", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, code_tab[4], 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_low", 32'(bus.in_ready), 32'h0);
    checkOutput("bp_a_hold",    32'(bus.out_data), 32'h2F);
    checkOutput("bp_a_valid2",  32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_b_valid",   32'(bus.out_valid), 32'h1);
    checkOutput("bp_b_data",    32'(bus.out_data),  32'h00);
    checkOutput("bp_b_mask",    32'(bus.out_mask),  32'h2F);
    checkOutput("bp_ready_back", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_drained", 32'(bus.out_valid), 32'h0);

    // Flush: bits 0,1 = 1 then flush; second flush on empty accumulator emits nothing.
    applyStimulus(1'b1, 5'b00001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'b00000, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_not_yet", 32'(bus.out_valid), 32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_valid",    32'(bus.out_valid),   32'h1);
    checkOutput("fl_data",     32'(bus.out_data),    32'h03);
    checkOutput("fl_mask",     32'(bus.out_mask),    32'h03);
    checkOutput("fl_partial",  32'(bus.out_partial), 32'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_empty", 32'(bus.out_valid), 32'h0);

    // Reset mid-word with a held output word and three captured bits.
    bus.out_ready = 1'b0;
    sendWord(5'b11111);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, code_tab[i], 1'b0, 1'b1, 1'b0);
    checkOutput("mid_held", 32'(bus.out_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("mid_data",  32'(bus.out_data),  32'h0);
    checkOutput("mid_mask",  32'(bus.out_mask),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    sendWord(5'b10000);
    checkOutput("post_valid",    32'(bus.out_valid),    32'h1);
    checkOutput("post_data",     32'(bus.out_data),     32'h20);
    checkOutput("post_mask",     32'(bus.out_mask),     32'h2F);
    checkOutput("post_conflict", 32'(bus.out_conflict), 32'h0);
    checkOutput("post_partial",  32'(bus.out_partial),  32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_if_ds_rx.md
# mult_if_ds_rx

Capture-side partner of the priority-mux data selector. Each cycle it samples the selector's control code, late-control flag and serial select output. It decodes which source bit of the 8-bit word that code routed, and writes the sampled value into that bit of a shadow word. When every required bit is present, it hands the rebuilt word downstream over a valid/ready interface, with a per-bit valid mask and a conflict flag.

## Interface
- REQ_MASK, 8'h2F, source bits that must be captured before a word is emitted; only bits 0,1,2,3,5 are reachable, so other bits set here are ignored.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  sample qualifier.
- in_ready  out  1  block can accept a sample this cycle.
- in_c  in  5  selector control code C[4:0].
- in_late  in  1  selector late-arriving-control flag.
- in_z  in  1  selector output value for this sample.
- flush  in  1  level; emit the partial accumulator.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  rebuilt word; uncaptured bits are 0.
- out_mask  out  8  bit i = 1 means out_data[i] was captured.
- out_conflict  out  1  a captured bit was re-sampled with a different value.
- out_partial  out  1  word was emitted by flush, not by completion.

## Operation
- Decode index `idx` from in_c and in_late, first match wins:
  - C3 & !late & !C0 & C1 & !C2 -> 3
  - C0 -> 0
  - !C1 -> 1
  - C4 -> 2
  - otherwise -> 5
- Indices 4, 6 and 7 are never produced.
- A sample is accepted when in_valid & in_ready.
- On acceptance:
  - acc_data[idx] <= in_z and acc_mask[idx] <= 1.
  - If acc_mask[idx] was already 1 and acc_data[idx] != in_z, set acc_conflict. Sticky until the word transfers.
  - The last value written wins.
- Effective required mask: `req = REQ_MASK & 8'h2F`.
- Complete: after including the accepted sample, the accumulator mask covers req.
- Output register is free when !out_valid, or when out_valid & out_ready in the same cycle.
- Transfer when output is free and either of these holds:
  - completion, or
  - flush with a nonzero post-sample accumulator mask.
- On transfer:
  - the output register loads data, mask and conflict from the post-sample accumulator;
  - out_partial = 1 only if the transfer was not a completion;
  - the accumulator clears to zero data, zero mask and no conflict.
- in_ready = !(accumulator complete & output register not free) & !(flush & output register not free).
  - In words: stall only while a finished or flushed word is waiting for the output register.
- flush with an empty accumulator does nothing.
- flush held high for several cycles emits one partial word per nonempty accumulator.
- If req == 0, every accepted sample completes a one-bit word.
- Output register is a single entry. out_valid, out_data, out_mask, out_conflict and out_partial hold stable while out_valid & !out_ready.

## Timing
- Reset (async): out_valid=0, out_data=0, out_mask=0, out_conflict=0, out_partial=0, accumulator cleared. in_ready=1 one cycle after rst deasserts; it is combinational from state and is also 1 during the first cycle.
- Latency: the sample that completes the word is accepted at edge N; out_valid=1 after edge N, with no extra cycle.
- Back-to-back words are allowed: when out_ready=1 on the word's last cycle, a new completion transfers on the same edge.
- Simultaneous accept and flush: the sample is included first, then the word transfers at the same edge.
- Simultaneous completion and flush: the word is reported as complete (out_partial=0).
- rst asserted mid-word: the accumulator and output register are lost immediately, and no word is emitted.

## Test plan
- Reachable bits:
  - Stimulus: five samples with in_c = 5'b00001 (z=1), 5'b00000 (z=0), 5'b10010 (z=1), 5'b01010 with late=0 (z=1), 5'b00010 (z=1); out_ready=1.
  - Response: out_valid the cycle after the fifth sample, out_data=8'h2D, out_mask=8'h2F, conflict=0, partial=0.
- Late gating:
  - Stimulus: in_c=5'b01010 with in_late=1, z=1.
  - Response: the sample decodes to bit 5, not bit 3.
- Conflict:
  - Stimulus: bit 0 sampled z=1 then z=0, then the remaining bits are filled.
  - Response: out_data[0]=0, out_conflict=1.
- Backpressure:
  - Stimulus: hold out_ready=0, complete word A, then complete word B.
  - Response: in_ready drops after B completes; A stays stable. One cycle of out_ready=1 drains A and loads B at the same edge.
- Flush:
  - Stimulus: capture bits 0 and 1 (z=1,1), then assert flush for one cycle.
  - Response: out_data=8'h03, out_mask=8'h03, out_partial=1; a flush on the empty accumulator the next cycle emits nothing.
- Reset mid-word:
  - Stimulus: capture three bits, pulse rst.
  - Response: all outputs are 0 immediately; the next full sequence emits a clean word with only its own bits set.
